// File: rtl/dec_fpr_wb_arb.sv
// dec_fpr_wb_arb: write-back arbiter and pending-write scoreboard for the single
// write port (wen0/waddr0/wd0) of the FP/GP register file.
//
// Ports:
//   clk, rst_l                      clock, asynchronous active-low reset
//   req0_valid/addr/data, req0_ready FPU arithmetic result source
//   req1_valid/addr/data, req1_ready load / int-to-fp move result source
//   wen0, waddr0, wd0               registered register-file write port
//   sb_set, sb_set_addr             mark a destination pending at issue
//   chk_addr0..2                    rs1/rs2/rd of the instruction in decode
//   hazard                          any checked register still pending
//   sb_busy                         pending bitmap (bit 0 always 0)
//
// req0 normally wins ties; after STARVE_MAX consecutive lost cycles req1 is
// favoured until it completes a transfer.

module dec_fpr_wb_arb #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            req0_valid,
  input  logic [4:0]      req0_addr,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [4:0]      req1_addr,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  output logic            wen0,
  output logic [4:0]      waddr0,
  output logic [XLEN-1:0] wd0,
  input  logic            sb_set,
  input  logic [4:0]      sb_set_addr,
  input  logic [4:0]      chk_addr0,
  input  logic [4:0]      chk_addr1,
  input  logic [4:0]      chk_addr2,
  output logic            hazard,
  output logic [31:0]     sb_busy
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [0:0] {StP0, StP1} prio_e;

  prio_e          state_q;
  logic [3:0]     starve_q;
  logic [3:0]     starve_d;
  logic [31:0]    busy_q;
  logic [31:0]    busy_d;
  logic [31:0]    set_mask;
  logic [31:0]    clr_mask;
  logic           grant0;
  logic           grant1;
  logic           wr_en;
  logic [4:0]     wr_addr;
  logic [XLEN-1:0] wr_data;

  // Grants are forced low while reset is asserted so nothing is accepted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_l) begin
      if (req0_valid && req1_valid) begin
        if (state_q == StP1) grant1 = 1'b1;
        else                 grant0 = 1'b1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Counts consecutive cycles req1 waits; saturates so P1 entry is stable.
  always_comb begin
    starve_d = 4'd0;
    if (req1_valid && !grant1) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
    end
  end

  // Writes to x0 are accepted but never reach the register file.
  always_comb begin
    wr_en   = (grant0 && (req0_addr != 5'd0)) || (grant1 && (req1_addr != 5'd0));
    wr_addr = grant1 ? req1_addr : req0_addr;
    wr_data = grant1 ? req1_data : req0_data;
  end

  // Set is applied after clear so an issue racing a write-back keeps the bit.
  always_comb begin
    set_mask = (sb_set && (sb_set_addr != 5'd0)) ? (32'd1 << sb_set_addr) : 32'd0;
    clr_mask = wen0 ? (32'd1 << waddr0) : 32'd0;
    busy_d   = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= StP0;
      starve_q <= 4'd0;
      busy_q   <= 32'd0;
      wen0     <= 1'b0;
      waddr0   <= 5'd0;
      wd0      <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
      unique case (state_q)
        StP0:    if (starve_d == StarveMax) state_q <= StP1;
        StP1:    if (grant1) state_q <= StP0;
        default: state_q <= StP0;
      endcase
      wen0 <= wr_en;
      if (wr_en) begin
        waddr0 <= wr_addr;
        wd0    <= wr_data;
      end
    end
  end

  // Pending bit still clear-pending during the wen0 cycle, so hazard holds there.
  assign hazard  = rst_l & (busy_q[chk_addr0] | busy_q[chk_addr1] | busy_q[chk_addr2]);
  assign sb_busy = busy_q;

endmodule

// File: tb/tb_dec_fpr_wb_arb.sv
module tb_dec_fpr_wb_arb;

  localparam int XL = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]    req0_addr = '0, req1_addr = '0;
  logic [XL-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          wen0;
  logic [4:0]    waddr0;
  logic [XL-1:0] wd0;
  logic          sb_set = 1'b0;
  logic [4:0]    sb_set_addr = '0;
  logic [4:0]    chk_addr0 = '0, chk_addr1 = '0, chk_addr2 = '0;
  logic          hazard;
  logic [31:0]   sb_busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: req1 is "owed" priority once it has lost SM cycles in a row.
  bit            m_owed;
  int            m_losses;
  bit            m_wen;
  bit [4:0]      m_waddr;
  bit [XL-1:0]   m_wd;
  bit [31:0]     m_busy;

  dec_fpr_wb_arb #(.XLEN(XL), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_l(rst_l),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .wen0(wen0), .waddr0(waddr0), .wd0(wd0),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .chk_addr0(chk_addr0), .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .hazard(hazard), .sb_busy(sb_busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owed = 0; m_losses = 0; m_wen = 0; m_waddr = '0; m_wd = '0; m_busy = '0;
  endtask

  function automatic void exp_grant(output bit g0, output bit g1);
    g0 = 0; g1 = 0;
    if (rst_l) begin
      if (req0_valid && req1_valid) begin
        g1 = m_owed; g0 = !m_owed;
      end else begin
        g0 = req0_valid; g1 = req1_valid;
      end
    end
  endfunction

  function automatic bit exp_hazard();
    return rst_l && (m_busy[chk_addr0] || m_busy[chk_addr1] || m_busy[chk_addr2]);
  endfunction

  // Advance one clock edge, updating the model from the pre-edge inputs.
  task automatic tick();
    bit g0, g1;
    bit [31:0] nb;
    exp_grant(g0, g1);
    @(posedge clk);
    if (!rst_l) begin
      model_reset();
    end else begin
      if (req1_valid && !g1) m_losses = (m_losses < SM) ? m_losses + 1 : SM;
      else                   m_losses = 0;
      if (g1) m_owed = 0;
      else if (m_losses == SM) m_owed = 1;
      nb = m_busy;
      if (m_wen) nb[m_waddr] = 1'b0;
      if (sb_set && sb_set_addr != 0) nb[sb_set_addr] = 1'b1;
      m_busy = nb;
      m_wen = 0;
      if (g0 && req0_addr != 0) begin
        m_wen = 1; m_waddr = req0_addr; m_wd = req0_data;
      end else if (g1 && req1_addr != 0) begin
        m_wen = 1; m_waddr = req1_addr; m_wd = req1_data;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    req0_valid = 1; req1_valid = 1; req0_addr = 5'd3; req1_addr = 5'd4;
    #1;
    n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); end
    n_cmp++; if (wen0 !== 1'b0 || waddr0 !== 5'd0 || wd0 !== '0) begin
      n_err++; $display("FAIL reset_wport: got %b %h %h want 0 00 0", wen0, waddr0, wd0); end
    n_cmp++; if (sb_busy !== 32'd0 || hazard !== 1'b0) begin
      n_err++; $display("FAIL reset_sb: got %h %b want 0 0", sb_busy, hazard); end
    tick(); tick();
    rst_l = 1; req0_valid = 0; req1_valid = 0;
    tick();
  endtask

  task automatic test_basic();
    req0_valid = 1; req0_addr = 5'd5; req0_data = 32'h3F80_0000;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin
      n_err++; $display("FAIL basic_ready: got %b want 1", req0_ready); end
    tick();
    req0_valid = 0;
    #1;
    n_cmp++; if (wen0 !== 1'b1 || waddr0 !== 5'd5 || wd0 !== 32'h3F80_0000) begin
      n_err++; $display("FAIL basic_write: got %b %h %h want 1 05 3f800000", wen0, waddr0, wd0);
    end
    tick();
    #1;
    n_cmp++; if (wen0 !== 1'b0) begin
      n_err++; $display("FAIL basic_pulse: got %b want 0", wen0); end
  endtask

  task automatic test_starve();
    bit exp0 [6] = '{1, 1, 1, 1, 0, 1};
    req0_valid = 1; req0_addr = 5'd1; req0_data = 32'h1111_0000;
    req1_valid = 1; req1_addr = 5'd2; req1_data = 32'h2222_0000;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++; if (req0_ready !== exp0[i] || req1_ready !== !exp0[i]) begin
        n_err++;
        $display("FAIL starve_cycle%0d: got r0=%b r1=%b want r0=%b", i + 1, req0_ready,
                 req1_ready, exp0[i]);
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    tick(); tick();
  endtask

  task automatic test_hazard();
    chk_addr0 = 5'd7; chk_addr1 = 5'd0; chk_addr2 = 5'd0;
    sb_set = 1; sb_set_addr = 5'd7;
    #1;
    n_cmp++; if (hazard !== 1'b0) begin
      n_err++; $display("FAIL haz_before: got %b want 0", hazard); end
    tick();
    sb_set = 0;
    #1;
    n_cmp++; if (hazard !== 1'b1 || sb_busy[7] !== 1'b1) begin
      n_err++; $display("FAIL haz_set: got %b busy=%h want 1", hazard, sb_busy); end
    req0_valid = 1; req0_addr = 5'd7; req0_data = 32'hCAFE_0007;
    tick();
    req0_valid = 0;
    #1;
    n_cmp++; if (wen0 !== 1'b1 || waddr0 !== 5'd7 || hazard !== 1'b1) begin
      n_err++; $display("FAIL haz_wen: got wen=%b a=%h hz=%b want 1 07 1", wen0, waddr0, hazard);
    end
    tick();
    #1;
    n_cmp++; if (hazard !== 1'b0 || sb_busy[7] !== 1'b0) begin
      n_err++; $display("FAIL haz_clear: got %b busy=%h want 0", hazard, sb_busy); end
  endtask

  task automatic test_set_wins();
    sb_set = 1; sb_set_addr = 5'd9;
    tick();
    sb_set = 0;
    req0_valid = 1; req0_addr = 5'd9; req0_data = 32'h0000_0099;
    tick();
    req0_valid = 0;
    sb_set = 1; sb_set_addr = 5'd9; chk_addr0 = 5'd9;
    #1;
    n_cmp++; if (wen0 !== 1'b1 || waddr0 !== 5'd9 || hazard !== 1'b1) begin
      n_err++; $display("FAIL setwin_pre: got wen=%b a=%h hz=%b want 1 09 1", wen0, waddr0, hazard);
    end
    tick();
    sb_set = 0;
    #1;
    n_cmp++; if (sb_busy !== 32'h0000_0200 || hazard !== 1'b1) begin
      n_err++; $display("FAIL setwin_post: got %h hz=%b want 00000200 1", sb_busy, hazard); end
  endtask

  task automatic test_addr0();
    req1_valid = 1; req1_addr = 5'd0; req1_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (req1_ready !== 1'b1) begin
      n_err++; $display("FAIL addr0_ready: got %b want 1", req1_ready); end
    tick();
    req1_valid = 0;
    #1;
    n_cmp++; if (wen0 !== 1'b0 || sb_busy !== 32'h0000_0200) begin
      n_err++; $display("FAIL addr0_nowrite: got wen=%b busy=%h want 0 00000200", wen0, sb_busy);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    sb_set = 1; sb_set_addr = 5'd7;
    tick();
    sb_set = 0;
    req0_valid = 1; req0_addr = 5'd3; req0_data = 32'h3333_3333;
    tick();
    req1_valid = 1; req1_addr = 5'd6;
    #1;
    n_cmp++; if (wen0 !== 1'b1 || sb_busy !== 32'h0000_0280) begin
      n_err++; $display("FAIL rstmid_pre: got wen=%b busy=%h want 1 00000280", wen0, sb_busy); end
    rst_l = 0;
    #1;
    n_cmp++; if (wen0 !== 1'b0 || sb_busy !== 32'd0 || req0_ready !== 1'b0 ||
                 req1_ready !== 1'b0 || hazard !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_async: got wen=%b busy=%h r=%b%b hz=%b want 0 0 00 0", wen0,
               sb_busy, req0_ready, req1_ready, hazard);
    end
    tick();
    rst_l = 1; req0_valid = 0; req1_valid = 1; req1_addr = 5'd4; req1_data = 32'h4444_0004;
    #1;
    n_cmp++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_err++; $display("FAIL rstmid_grant: got r0=%b r1=%b want 0 1", req0_ready, req1_ready);
    end
    tick();
    req1_valid = 0;
    #1;
    n_cmp++; if (wen0 !== 1'b1 || waddr0 !== 5'd4 || wd0 !== 32'h4444_0004) begin
      n_err++; $display("FAIL rstmid_write: got %b %h %h want 1 04 44440004", wen0, waddr0, wd0);
    end
    tick();
  endtask

  task automatic test_random();
    bit g0, g1;
    for (int c = 0; c < 600; c++) begin
      if (!req0_valid && $urandom_range(0, 99) < 55) begin
        req0_valid = 1; req0_addr = 5'($urandom_range(0, 15)); req0_data = $urandom;
      end
      if (!req1_valid && $urandom_range(0, 99) < 55) begin
        req1_valid = 1; req1_addr = 5'($urandom_range(0, 15)); req1_data = $urandom;
      end
      sb_set      = ($urandom_range(0, 99) < 35);
      sb_set_addr = 5'($urandom_range(0, 15));
      chk_addr0   = 5'($urandom_range(0, 15));
      chk_addr1   = 5'($urandom_range(0, 31));
      chk_addr2   = 5'($urandom_range(0, 15));
      #1;
      exp_grant(g0, g1);
      n_cmp++; if (req0_ready !== g0 || req1_ready !== g1) begin
        n_err++; $display("FAIL rnd_grant c%0d: got %b%b want %b%b", c, req0_ready, req1_ready,
                          g0, g1);
      end
      n_cmp++; if (wen0 !== m_wen || (m_wen && (waddr0 !== m_waddr || wd0 !== m_wd))) begin
        n_err++; $display("FAIL rnd_write c%0d: got %b %h %h want %b %h %h", c, wen0, waddr0, wd0,
                          m_wen, m_waddr, m_wd);
      end
      n_cmp++; if (sb_busy !== m_busy || hazard !== exp_hazard()) begin
        n_err++; $display("FAIL rnd_sb c%0d: got %h %b want %h %b", c, sb_busy, hazard, m_busy,
                          exp_hazard());
      end
      tick();
      if (g0) req0_valid = 0;
      if (g1) req1_valid = 0;
    end
    req0_valid = 0; req1_valid = 0; sb_set = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_starve();
    test_hazard();
    test_set_wins();
    test_addr0();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
